alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the lab combinational ALU.
- Operates on two W-bit operands with a 3-bit opcode and produces a 2W-bit registered result.
- Uses a valid/ready handshake on both input and output.
- Adds an accumulate mode that feeds the last result back, and a multi-cycle shift-add multiplier.
- Sits between switch/key input logic and the LEDR/hex display path.

Parameters:
- W, 4, operand width in bits; legal values are W >= 2; result width is 2W.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  3  opcode, sampled on accept.
- a  input  W  operand A.
- b  input  W  operand B.
- out_valid  output  1  result is valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- result  output  2W  registered result.
- busy  output  1  high while in MUL state.
- err  output  1  registered; high with out_valid when the opcode was unsupported.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-low (resetn).
  - On resetn=0: state=IDLE, result=0, out_valid=0, busy=0, err=0, multiply counter=0. in_ready=1 once reset is released.
- Accept and latency:
  - Accept occurs when in_valid & in_ready are both high at a rising edge; op, a and b are latched at that edge.
  - Single-cycle ops: result is loaded at the accept edge; out_valid=1 from the next cycle (latency 1).
- Opcodes (zero-extend every result to 2W bits):
  - 0 ADD: {carry, a+b}, W+1 bits.
  - 1 SUB: (a-b) mod 2^W in bits [W-1:0]; borrow (a<b) in bit W.
  - 2 XOROR: upper W bits = a|b, lower W bits = a^b.
  - 3 ROR: 1 if |{a,b}, else 0.
  - 4 RAND: 1 if &{a,b}, else 0.
  - 5 CAT: {b, a}, with b in the upper half.
  - 6 MUL: a*b, unsigned, full 2W bits, multi-cycle.
  - 7 ACC: (result_prev + {0,a}) mod 2^2W.
    - result_prev is the last result register value, whether or not it has been consumed.
    - After reset, result_prev = 0.
- State machine:
  - IDLE: in_ready=1.
    - On accept with op=6, go to MUL: clear the product, load multiplicand and multiplier, counter=0.
    - On accept with any other op, go to HOLD.
  - MUL: busy=1, in_ready=0.
    - Each cycle: if multiplier LSB=1, add the shifted multiplicand; shift; counter++.
    - After W iterations, load result and go to HOLD.
    - MUL latency: out_valid rises W+1 cycles after the accept edge.
  - HOLD: out_valid=1, result and err stable.
    - On out_ready=1, go to IDLE and clear out_valid. result keeps its value for ACC.
    - in_ready=0 while in HOLD. Sustained throughput is one op per 2 cycles (single-cycle ops).
- Boundary conditions:
  - in_valid while not in IDLE: ignored; the source must hold its values.
  - out_ready while not in HOLD: no effect.
  - ADD overflow is carried into bit W. SUB wraps mod 2^W. ACC wraps mod 2^2W silently.
  - resetn asserted mid-MUL or in HOLD: immediate return to reset values; the partial product is discarded.
  - op changing after accept has no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 6 is implemented as described above.
- Undefined:
  - No multiplier datapath or MUL state is built; busy is tied to 0.
  - op 6 goes to HOLD with latency 1, result=0 and err=1.
  - All other ops give err=0.

Test Plan:
- W=4: ADD a=4'hF, b=4'h1 -> result 8'h10, out_valid exactly 1 cycle after accept, err=0.
- W=4: XOROR a=5, b=3 -> 8'h76. CAT a=3, b=A -> 8'hA3. RAND a=F, b=F -> 8'h01. SUB a=2, b=3 -> 8'h1F.
- W=4, MUL_EN defined: MUL a=F, b=F -> 8'hE1.
  - out_valid exactly 5 cycles after accept.
  - busy=1 for 4 cycles.
  - in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 10 cycles after an ADD.
  - result and out_valid stay stable.
  - in_ready stays 0.
  - A new in_valid pulse is ignored.
  - Release out_ready -> IDLE the next cycle.
- ACC: reset, then ACC a=5 -> 8'h05; ACC a=F -> 8'h14; ADD 1+1 -> 8'h02; ACC a=1 -> 8'h03.
- Reset: assert resetn=0 on the 2nd MUL cycle -> outputs cleared immediately and in_ready=1 after release. With MUL_EN undefined, op 6 -> result 0, err=1.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, handshaked ALU with an accumulate mode and an
// optional multi-cycle shift-add multiplier.
//
// Operands a/b (W bits) and a 3-bit opcode are taken on an in_valid/in_ready
// handshake. The 2W-bit result is held, with out_valid, until out_ready.
//
// Optional feature: define ALU_SEQ_MUL_EN to build the shift-add multiplier
// (op 6). Without it, op 6 completes in one cycle with result 0 and err=1,
// and busy is tied low.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous, active-low reset
//   in_valid   operands/opcode presented
//   in_ready   block can accept (IDLE only)
//   op, a, b   opcode and operands, sampled on accept
//   out_valid  result valid, held until consumed
//   out_ready  consumer accepts result
//   result     registered 2W-bit result
//   busy       high while the multiplier iterates
//   err        high with out_valid when the opcode was unsupported
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t           r_state;
  logic [2*W-1:0]   r_result;
  logic             r_out_valid;
  logic             r_err;

  logic [W:0]       w_add;
  logic [W:0]       w_sub;
  logic [2*W-1:0]   w_res;
  logic             w_err;

  // Bit W of the W+1-bit difference is the borrow (a < b).
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (op)
      3'd0: w_res = {{(W-1){1'b0}}, w_add};
      3'd1: w_res = {{(W-1){1'b0}}, w_sub};
      3'd2: w_res = {a | b, a ^ b};
      3'd3: w_res = {{(2*W-1){1'b0}}, |{a, b}};
      3'd4: w_res = {{(2*W-1){1'b0}}, &{a, b}};
      3'd5: w_res = {b, a};
      3'd7: w_res = r_result + {{W{1'b0}}, a};  // wraps mod 2^2W
      default: begin
        // op 6 only reaches this path when the multiplier is not built.
        w_res = '0;
`ifndef ALU_SEQ_MUL_EN
        w_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_prod;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [2*W-1:0]   w_prod_next;

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign busy        = r_busy;
`else
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == 3'd6) begin
              r_state  <= S_MUL;
              r_busy   <= 1'b1;
              r_prod   <= '0;
              r_mcand  <= {{W{1'b0}}, a};
              r_mplier <= b;
              r_cnt    <= '0;
            end else
`endif
            begin
              r_state     <= S_HOLD;
              r_result    <= w_res;
              r_err       <= w_err;
              r_out_valid <= 1'b1;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          // One partial product per cycle; the last iteration's sum goes
          // straight into result so out_valid appears W+1 cycles after accept.
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_state     <= S_HOLD;
            r_result    <= w_prod_next;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
`endif
        S_HOLD: begin
          // result is kept after consumption; ACC builds on it.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           busy;
  logic           err;

  int checks = 0;
  int errors = 0;
  longint prev = 0;  // model of the result register, for ACC

  alu_seq #(.W(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    logic           eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the opcode table.
  function automatic longint model(input int o, input int x, input int y, input longint p);
    longint full = longint'(1) << (2 * W);
    case (o)
      0: return x + y;
      1: return ((x - y) & MASK) + ((x < y) ? (1 << W) : 0);
      2: return ((x | y) << W) | (x ^ y);
      3: return (x != 0 || y != 0) ? 1 : 0;
      4: return (x == MASK && y == MASK) ? 1 : 0;
      5: return (y << W) | x;
      6: return MUL_ON ? longint'(x * y) : 0;
      default: return (p + x) % full;
    endcase
  endfunction

  function automatic int exp_lat(input int o);
    return (o == 6 && MUL_ON) ? W + 1 : 1;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    // Scramble inputs after accept: they must have no effect.
    in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  // Called #1 after the accept edge; latency 1 means out_valid is seen here.
  task automatic await_out(input int elat, input int ebusy);
    int lat = 1;
    int bcnt = 0;
    int ir_hi = 0;
    bcnt += busy; ir_hi += in_ready;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bcnt += busy; ir_hi += in_ready;
    end
    chk("latency", lat, elat);
    chk("busy_cycles", bcnt, ebusy);
    chk("in_ready_low_while_busy", ir_hi, 0);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_cleared", out_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] e, input logic ee, input string nm);
    issue(o, x, y);
    await_out(exp_lat(o), (o == 6 && MUL_ON) ? W : 0);
    chk({nm, "_result"}, result, e);
    chk({nm, "_err"}, err, ee);
    consume();
    prev = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    prev = 0;
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{3'd0, 4'hF, 4'h1, 8'h10, 1'b0};
    vt[1]  = '{3'd2, 4'h5, 4'h3, 8'h76, 1'b0};
    vt[2]  = '{3'd5, 4'h3, 4'hA, 8'hA3, 1'b0};
    vt[3]  = '{3'd4, 4'hF, 4'hF, 8'h01, 1'b0};
    vt[4]  = '{3'd1, 4'h2, 4'h3, 8'h1F, 1'b0};
    vt[5]  = '{3'd3, 4'h0, 4'h0, 8'h00, 1'b0};
    vt[6]  = '{3'd3, 4'h0, 4'h8, 8'h01, 1'b0};
    vt[7]  = '{3'd4, 4'hF, 4'h7, 8'h00, 1'b0};
    vt[8]  = '{3'd1, 4'h7, 4'h7, 8'h00, 1'b0};
    vt[9]  = '{3'd0, 4'hF, 4'hF, 8'h1E, 1'b0};
    vt[10] = MUL_ON ? '{3'd6, 4'hF, 4'hF, 8'hE1, 1'b0} : '{3'd6, 4'hF, 4'hF, 8'h00, 1'b1};

    #2;
    chk("rst_out_valid_init", out_valid, 0);
    chk("rst_result_init", result, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready_init", in_ready, 1);

    // Directed table.
    for (int i = 0; i < 11; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].eerr, $sformatf("vec%0d", i));

    // Accumulate chain from reset.
    do_reset();
    run_op(3'd7, 4'h5, 4'h0, 8'h05, 1'b0, "acc1");
    run_op(3'd7, 4'hF, 4'h9, 8'h14, 1'b0, "acc2");
    run_op(3'd0, 4'h1, 4'h1, 8'h02, 1'b0, "acc_add");
    run_op(3'd7, 4'h1, 4'h0, 8'h03, 1'b0, "acc3");

    // Backpressure: result held for 10 cycles, a stray in_valid is ignored.
    issue(3'd0, 4'h9, 4'h8);
    await_out(1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, 8'h11);
      chk("bp_in_ready", in_ready, 0);
      if (i == 4) begin in_valid = 1'b1; op = 3'd5; a = 4'h3; b = 4'h4; end
      if (i == 5) in_valid = 1'b0;
    end
    consume();
    chk("bp_result_kept", result, 8'h11);
    prev = 8'h11;
    run_op(3'd7, 4'h0, 4'h0, 8'h11, 1'b0, "bp_acc");

    // Reset while holding an unconsumed result.
    issue(3'd0, 4'hF, 4'h1);
    await_out(1, 0);
    do_reset();

    // Reset during the second multiply cycle.
    if (MUL_ON) begin
      issue(3'd6, 4'hD, 4'hB);
      chk("mul_busy_c1", busy, 1);
      @(posedge clk); #1;
      chk("mul_busy_c2", busy, 1);
      do_reset();
      run_op(3'd7, 4'h2, 4'h0, 8'h02, 1'b0, "post_mul_rst_acc");
    end else begin
      run_op(3'd6, 4'h3, 4'h5, 8'h00, 1'b1, "mul_disabled");
    end

    // Random ops against the model.
    for (int i = 0; i < 60; i++) begin
      int o = $urandom_range(0, 7);
      int x = $urandom_range(0, MASK);
      int y = $urandom_range(0, MASK);
      longint e = model(o, x, y, prev);
      run_op(3'(o), W'(x), W'(y), (2*W)'(e), (o == 6 && !MUL_ON), $sformatf("rnd%0d_op%0d", i, o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
